// File: rtl/bpu_defs_pkg.sv
// Definitions shared by the bimodal predictor and its update queue.
// Fixes the PC width and the bit layout of an update-info word: {pc, taken}.
package bpu_defs;

    localparam int PC_WIDTH  = 32;
    localparam int INFO_W    = PC_WIDTH + 1;

    // taken sits in bit 0, the pc occupies bits PC_WIDTH:1
    localparam int TAKEN_BIT = 0;
    localparam int PC_LSB    = 1;
    localparam int PC_MSB    = PC_WIDTH;

    typedef logic [INFO_W-1:0] bpu_info_t;

    function automatic bpu_info_t bpu_pack_info(input logic [PC_WIDTH-1:0] pc, input logic taken);
        bpu_info_t info;
        info            = '0;
        info[PC_MSB:PC_LSB] = pc;
        info[TAKEN_BIT] = taken;
        return info;
    endfunction

    function automatic logic [PC_WIDTH-1:0] bpu_info_pc(input bpu_info_t info);
        return info[PC_MSB:PC_LSB];
    endfunction

    function automatic logic bpu_info_taken(input bpu_info_t info);
        return info[TAKEN_BIT];
    endfunction

endpackage

// File: rtl/bpu_sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers, flush and full/empty flags.
// Storage is not reset; only the pointers are, so stale entries are never visible.
module bpu_sync_fifo #(
    parameter int DATA_W     = 33,
    parameter int DEPTH_EXP2 = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << DEPTH_EXP2;
    localparam int PTR_W = DEPTH_EXP2 + 1;

    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full_o  = (wptr_q[DEPTH_EXP2-1:0] == rptr_q[DEPTH_EXP2-1:0]) &&
                     (wptr_q[DEPTH_EXP2] != rptr_q[DEPTH_EXP2]);
    assign empty_o = (wptr_q == rptr_q);

    // flush wins over any same-cycle push or pop
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign rdata_o = mem_q[rptr_q[DEPTH_EXP2-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[DEPTH_EXP2-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/branch_update_queue.sv
// Buffers resolved conditional branches and drains them as {pc, taken} predictor updates.
// Optional statistics counters are built only when BPU_UPDATE_STATS_EN is defined.
module branch_update_queue #(
    parameter int PC_WIDTH   = bpu_defs::PC_WIDTH,
    parameter int DEPTH_EXP2 = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 resolve_valid,
    output logic                 resolve_ready,
    input  logic [PC_WIDTH-1:0]  resolve_pc,
    input  logic                 resolve_taken,
    input  logic                 resolve_is_cond,
    input  logic                 resolve_mispredict,
    output logic                 update_valid,
    input  logic                 update_ready,
    output logic [PC_WIDTH:0]    update_instr_info,
    output logic [CNT_WIDTH-1:0] stat_branch_cnt,
    output logic [CNT_WIDTH-1:0] stat_mispredict_cnt
);

    import bpu_defs::*;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [PC_WIDTH:0] push_data;

    // Non-conditional beats still handshake; they just never reach storage.
    assign resolve_ready = !fifo_full;
    assign update_valid  = !fifo_empty;
    assign push          = resolve_valid && resolve_ready && resolve_is_cond && !flush;
    assign pop           = update_valid && update_ready && !flush;

    always_comb begin
        push_data                 = '0;
        push_data[PC_WIDTH:PC_LSB] = resolve_pc;
        push_data[TAKEN_BIT]      = resolve_taken;
    end

    bpu_sync_fifo #(
        .DATA_W     (PC_WIDTH + 1),
        .DEPTH_EXP2 (DEPTH_EXP2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (update_instr_info),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef BPU_UPDATE_STATS_EN
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;

    // Saturating counters; flush deliberately leaves them alone.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (push) begin
            if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
            if (resolve_mispredict && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign stat_branch_cnt     = br_cnt_q;
    assign stat_mispredict_cnt = mp_cnt_q;
`else
    logic unused_mispredict;

    assign unused_mispredict   = resolve_mispredict;
    assign stat_branch_cnt     = '0;
    assign stat_mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized and directed bench for branch_update_queue against a queue-based reference model.
module tb_branch_update_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        resolve_valid;
    logic        resolve_ready;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_is_cond;
    logic        resolve_mispredict;
    logic        update_valid;
    logic        update_ready;
    logic [32:0] update_instr_info;
    logic [31:0] stat_branch_cnt;
    logic [31:0] stat_mispredict_cnt;

    branch_update_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .resolve_valid       (resolve_valid),
        .resolve_ready       (resolve_ready),
        .resolve_pc          (resolve_pc),
        .resolve_taken       (resolve_taken),
        .resolve_is_cond     (resolve_is_cond),
        .resolve_mispredict  (resolve_mispredict),
        .update_valid        (update_valid),
        .update_ready        (update_ready),
        .update_instr_info   (update_instr_info),
        .stat_branch_cnt     (stat_branch_cnt),
        .stat_mispredict_cnt (stat_mispredict_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [32:0] mq[$];
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Drive one cycle from just after a falling edge, check, advance the model, then
    // return at the next falling edge.
    task automatic step(input logic r, input logic fl, input logic rv, input logic [31:0] pc,
                        input logic tk, input logic cond, input logic mp, input logic ur);
        logic can_push;
        logic has_head;
        rst = r; flush = fl; resolve_valid = rv; resolve_pc = pc;
        resolve_taken = tk; resolve_is_cond = cond; resolve_mispredict = mp; update_ready = ur;
        #1;
        can_push = (mq.size() < DEPTH);
        has_head = (mq.size() != 0);
        check("resolve_ready", 64'(resolve_ready), 64'(can_push));
        check("update_valid", 64'(update_valid), 64'(has_head));
        if (has_head) check("update_info", 64'(update_instr_info), 64'(mq[0]));
`ifdef BPU_UPDATE_STATS_EN
        check("stat_branch", 64'(stat_branch_cnt), 64'(exp_br));
        check("stat_mispredict", 64'(stat_mispredict_cnt), 64'(exp_mp));
`else
        check("stat_branch_tied", 64'(stat_branch_cnt), 64'd0);
        check("stat_mispredict_tied", 64'(stat_mispredict_cnt), 64'd0);
`endif
        if (r) begin
            mq.delete();
            exp_br = 0;
            exp_mp = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (has_head && ur) void'(mq.pop_front());
            if (rv && can_push && cond) begin
                mq.push_back({pc, tk});
                if (exp_br != 32'hFFFF_FFFF) exp_br++;
                if (mp && exp_mp != 32'hFFFF_FFFF) exp_mp++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ur, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 0, ur);
    endtask

    initial begin
        logic [32:0] held;
        rst = 1; flush = 0; resolve_valid = 0; resolve_pc = 0; resolve_taken = 0;
        resolve_is_cond = 0; resolve_mispredict = 0; update_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mq.delete();

        // single push, one-cycle latency, drained next cycle
        step(0, 0, 1, 32'h1C00_0010, 1, 1, 0, 1);
        check("tp1_valid", 64'(update_valid), 64'd1);
        check("tp1_info", 64'(update_instr_info), 64'h3800_0021);
        idle(1, 2);

        // fill to full under backpressure, then drain in order
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h1C00_0020 + 32'(i * 4), i[0], 1, 0, 0);
        check("full_ready", 64'(resolve_ready), 64'd0);
        step(0, 0, 1, 32'h1C00_0AA0, 1, 1, 0, 0);
        idle(1, DEPTH + 1);

        // non-conditional filter
        step(0, 0, 1, 32'h1C00_0040, 1, 0, 1, 1);
        check("noncond_empty", 64'(update_valid), 64'd0);
        idle(1, 1);

        // simultaneous push/pop at occupancy 2 across pointer wrap
        step(0, 0, 1, 32'h1C00_0050, 0, 1, 0, 0);
        step(0, 0, 1, 32'h1C00_0054, 1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h1C00_0060 + 32'(i * 4), i[1], 1, 0, 1);
        idle(1, 3);

        // backpressure hold
        step(0, 0, 1, 32'h1C00_0100, 0, 1, 0, 0);
        held = update_instr_info;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 32'h0, 0, 0, 0, 0);
            check("hold_info", 64'(update_instr_info), 64'(held));
        end
        step(0, 0, 0, 32'h0, 0, 0, 0, 1);
        check("hold_single_pop", 64'(update_valid), 64'd0);

        // flush with 3 entries plus concurrent push, then a mispredicted push
        for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h1C00_0200 + 32'(i * 4), 1, 1, 1, 0);
        step(0, 1, 1, 32'h1C00_0300, 1, 1, 1, 1);
        check("flush_empty", 64'(update_valid), 64'd0);
        check("flush_ready", 64'(resolve_ready), 64'd1);
        step(0, 0, 1, 32'h1C00_0400, 0, 1, 1, 0);
        idle(1, 2);

        // randomized traffic including mid-drain reset and flush
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 3) != 0,
                 $urandom,
                 1'($urandom),
                 $urandom_range(0, 3) != 0,
                 1'($urandom),
                 $urandom_range(0, 9) < 6);
        end
        idle(1, DEPTH + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
